// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and word-packing constants for imem_loader
// Contents: loader_state_t (FSM states), BYTES_PER_WORD, BYTE_CNT_W.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        ERROR = 3'd4,
        DONE  = 3'd5
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs accepted bytes little-endian into a 32-bit word
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   clear           discard the partial word and restart at lane 0
//   accept          a byte is transferred this cycle
//   byte_in         byte being transferred
//   word_next       assembled word including the byte transferred this cycle
//   word_full       strobe: this transfer fills the top lane
module loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        accept,
    input  logic [7:0]                  byte_in,
    output logic [8*BYTES_PER_WORD-1:0] word_next,
    output logic                        word_full
);

    logic [7:0]            lane [BYTES_PER_WORD];
    logic [BYTE_CNT_W-1:0] byte_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                lane[i] <= '0;
            end
            byte_cnt <= '0;
        end else if (accept) begin
            lane[byte_cnt] <= byte_in;
            byte_cnt       <= byte_cnt + BYTE_CNT_W'(1);
        end
    end

    // Merge the in-flight byte so the word can be captured on the same edge
    // that fills its last lane.
    always_comb begin
        word_next = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            word_next[8*i +: 8] = (accept && (byte_cnt == BYTE_CNT_W'(i))) ? byte_in : lane[i];
        end
    end

    assign word_full = accept && (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that writes instruction memory and holds the core in reset
// Optional checksum stage: IMEM_LOADER_CHECKSUM_EN
// Ports:
//   CLK, reset              clock and synchronous active-high reset
//   load_start, load_words  begin a load of load_words words (sampled in IDLE)
//   byte_in, byte_valid     byte stream in; byte_ready accepts it
//   imem_we, imem_addr      single-cycle write strobe, word-aligned byte address
//   imem_wd                 write data
//   cpu_reset               holds the core in reset while loading
//   load_done, load_error   completion pulse, checksum failure flag
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int IMEM_AW = 32
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               load_start,
    input  logic [ADDR_W:0]    load_words,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wd,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               load_error
);

    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(1 << ADDR_W);

    loader_state_t   state;
    loader_state_t   next_state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] word_idx;
    logic              start_load;
    logic              xfer;
    logic              accept;
    logic              word_full;
    logic              last_word;
    logic [31:0]       word_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    assign xfer      = byte_valid && byte_ready;
    // The checksum byte arrives in CHECK and must not enter the data word.
    assign accept    = xfer && (state == RECV);
    assign last_word = ({1'b0, word_idx} == (count - (ADDR_W+1)'(1)));

    loader_word_assembler u_asm (
        .clk       (CLK),
        .reset     (reset),
        .clear     (start_load),
        .accept    (accept),
        .byte_in   (byte_in),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_load = 1'b0;
        case (state)
            IDLE: begin
                if (load_start && (load_words != '0)) begin
                    start_load = 1'b1;
                    next_state = RECV;
                end
            end
            RECV: begin
                if (word_full) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = CHECK;
`else
                    next_state = DONE;
`endif
                end else begin
                    next_state = RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    next_state = (byte_in == checksum) ? DONE : ERROR;
                end
            end
            ERROR: begin
                if (load_start && (load_words != '0)) begin
                    start_load = 1'b1;
                    next_state = RECV;
                end
            end
`endif
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from next_state so they line up with the state
    // they belong to without any combinational path to the pins.
    always_ff @(posedge CLK) begin
        if (reset) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wd    <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            count      <= '0;
            word_idx   <= '0;
        end else begin
            byte_ready <= (next_state == RECV) || (next_state == CHECK);
            imem_we    <= (next_state == WRITE);
            load_done  <= (next_state == DONE);
            cpu_reset  <= (next_state != IDLE);

            if (start_load) begin
                count    <= (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
                word_idx <= '0;
            end

            if ((state == RECV) && word_full) begin
                imem_addr <= IMEM_AW'({word_idx, 2'b00});
                imem_wd   <= word_next;
            end

            if (state == WRITE) begin
                word_idx <= word_idx + ADDR_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            checksum   <= '0;
            load_error <= 1'b0;
        end else begin
            load_error <= (next_state == ERROR);
            if (start_load) begin
                checksum <= '0;
            end else if (accept) begin
                checksum <= checksum + byte_in;
            end
        end
    end
`else
    assign load_error = 1'b0;
`endif

endmodule
